cpu_rd_sequencer: RTL
=====================

Name: cpu_rd_sequencer

Overview:
- Clock-domain front end for the host parallel read bus of the eight-axis motor controller.
- Synchronises the asynchronous host RD/CS strobes into clk and decodes Addr[7:4] to a source.
- Sequences a request/acknowledge read from the selected axis core (or the Xin input port), with a timeout.
- Holds the returned byte stable on the DQ output for the rest of the strobe; replaces direct RD-edge-clocked capture.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the RD/CS synchronisers (legal 2..3).
- TIMEOUT, 15, clk cycles to wait in WAIT for axis_ack before aborting (legal 1..255).
- ERR_BYTE, 8'hEE, byte returned when an axis read times out.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; synchronous, active-low
- RD  in  1  host read strobe, asynchronous, active-low
- CS_n  in  1  host chip select, asynchronous, active-low
- Addr  in  8  host address; stable from RD fall to RD rise (bus rule)
- Xin  in  8  digital input port, read at Addr[7:4]=1
- axis_ack  in  8  per-axis read acknowledge, bit i = axis i+1
- axis_data  in  64  per-axis read data, byte i at [8i+7:8i], valid with axis_ack[i]
- rd_req  out  8  one-hot, one-cycle read request to axis i
- sub_addr  out  4  latched Addr[3:0], valid while rd_req is high and held until next capture
- DQ_out  out  8  read data to the pad tri-state
- DQ_oe  out  1  pad output enable
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky timeout flag
- err_clr  in  1  clears timeout_err (takes priority over a same-cycle set)

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; rd_req=0, sub_addr=0, DQ_out=0, DQ_oe=0, busy=0, timeout_err=0, timeout counter=0, synchronisers=1 (inactive).
- rd_s/cs_s: synchronised RD and CS_n after SYNC_STAGES flops.
- Read start: rd_s falls, detected as prev=1, now=0, while cs_s=0.
- DQ_oe = ~rd_s & ~cs_s, registered. Asserted in every state, including when no start was detected.
- States:
  - IDLE: on a read start, latch Addr and decode hi=Addr[7:4].
    - hi=1: DQ_out<=Xin, go HOLD.
    - hi=3..A: idx=hi-3, go REQ.
    - else: DQ_out<=8'h00, go HOLD.
  - REQ: rd_req[idx]=1 for exactly one cycle; clear counter; go WAIT.
  - WAIT:
    - axis_ack[idx]=1: DQ_out<=axis_data byte idx, go HOLD. The ack may arrive in the first WAIT cycle.
    - Acks on other bits are ignored.
    - counter==TIMEOUT-1 with no ack: DQ_out<=ERR_BYTE, timeout_err<=1, go HOLD.
    - Otherwise counter++.
  - HOLD: DQ_out stable. When rd_s=1, go IDLE. DQ_out keeps its value until the next capture.
- Aborted strobe: rd_s=1 while in REQ or WAIT.
  - Go IDLE; drop the request; DQ_out and timeout_err unchanged.
  - A late ack is ignored.
- Ack and timeout in the same cycle: ack wins, no error.
- CS_n rising mid-cycle: only DQ_oe drops; the FSM follows RD alone.
- A new read start is accepted only in IDLE. Edges seen in other states are discarded.
- Latency, RD fall to DQ_out valid (SYNC_STAGES=2):
  - Xin or unmapped: 4 clk.
  - Axis: 5 clk + ack delay.
- Host RD low time must cover worst case: 5+TIMEOUT clk.

Decomposition:
- Shared package cpu_bus_pkg:
  - Address-map constants: ADDR_XIN=4'h1, ADDR_AXIS_BASE=4'h3, NUM_AXIS=8.
  - FSM state enum {IDLE, REQ, WAIT, HOLD}.
  - ERR_BYTE default.
- One sub-module: sync_edge, a SYNC_STAGES synchroniser plus falling-edge detect. Instantiate it for RD and for CS_n.

Test Plan:
- Reset: hold rst_n=0 with RD=0 → all outputs 0, state IDLE. Release with RD=1 → no rd_req.
- Xin read: Xin=8'h5A, Addr=8'h10, RD low for 10 clk → DQ_out=8'h5A at 4 clk after RD fall, DQ_oe high, rd_req never set, IDLE after RD rise.
- Axis 3 read: Addr=8'h52 → rd_req=8'b0000_0100 for one cycle, sub_addr=2. axis_ack[2] after 3 clk with byte 8'hC3 → DQ_out=8'hC3, busy low after RD rise.
- Timeout: Addr=8'hA0, no ack, TIMEOUT=15 → after 15 WAIT cycles DQ_out=8'hEE, timeout_err=1.
  - Pulse err_clr → timeout_err=0.
  - err_clr concurrent with a new timeout → 0.
- Unmapped/abort: Addr=8'hF0 → DQ_out=8'h00. Axis read with RD rising during WAIT → IDLE, no error, late ack ignored.
- Wrong-axis ack: Addr=8'h30 with axis_ack[1] only → no capture, timeout path taken.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the host parallel read bus front end.
// Holds the address map of the read sources, the read sequencer state
// encoding and the byte returned on an axis read timeout.
package cpu_bus_pkg;

    // Addr[7:4] values selecting a read source
    localparam logic [3:0]  ADDR_XIN       = 4'h1;
    localparam logic [3:0]  ADDR_AXIS_BASE = 4'h3;
    localparam int unsigned NUM_AXIS       = 8;
    localparam logic [3:0]  ADDR_AXIS_LAST = ADDR_AXIS_BASE + 4'(NUM_AXIS - 1);

    localparam logic [7:0]  ERR_BYTE_DEFAULT = 8'hEE;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } rd_state_e;

    function automatic logic is_axis(input logic [3:0] hi);
        return (hi >= ADDR_AXIS_BASE) && (hi <= ADDR_AXIS_LAST);
    endfunction

    function automatic logic [2:0] axis_index(input logic [3:0] hi);
        return 3'(hi - ADDR_AXIS_BASE);
    endfunction

endpackage

// File: rtl/cpu_rd_sequencer_sync_edge.sv
// sync_edge: multi-flop synchroniser for an asynchronous active-low strobe,
// plus a registered falling-edge pulse on the synchronised level.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   din        : asynchronous input
//   sync       : synchronised level (resets to 1, i.e. strobe inactive)
//   fall       : one-cycle pulse, one clk after sync goes 1 -> 0
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic fall
);

    logic [SYNC_STAGES-1:0] ff_q;
    logic                   prev_q;
    logic                   fall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ff_q   <= '1;
            prev_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            ff_q   <= {ff_q[SYNC_STAGES-2:0], din};
            prev_q <= ff_q[SYNC_STAGES-1];
            fall_q <= prev_q & ~ff_q[SYNC_STAGES-1];
        end
    end

    assign sync = ff_q[SYNC_STAGES-1];
    assign fall = fall_q;

endmodule

// File: rtl/cpu_rd_sequencer.sv
// cpu_rd_sequencer: clk-domain front end for the host parallel read bus.
// Synchronises RD/CS_n, decodes Addr[7:4] to Xin, an axis core or nothing,
// runs a request/ack read against the selected axis with a timeout and holds
// the returned byte on DQ_out for the rest of the strobe.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   RD, CS_n         : asynchronous host strobes (active-low)
//   Addr, Xin        : host address, digital input port
//   axis_ack/data    : per-axis acknowledge and read byte
//   rd_req, sub_addr : one-hot one-cycle request and latched Addr[3:0]
//   DQ_out, DQ_oe    : read data and pad output enable
//   busy             : sequencer not in IDLE
//   timeout_err      : sticky timeout flag, cleared by err_clr
module cpu_rd_sequencer
    import cpu_bus_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 15,
    parameter logic [7:0]  ERR_BYTE    = ERR_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RD,
    input  logic        CS_n,
    input  logic [7:0]  Addr,
    input  logic [7:0]  Xin,
    input  logic [7:0]  axis_ack,
    input  logic [63:0] axis_data,
    output logic [7:0]  rd_req,
    output logic [3:0]  sub_addr,
    output logic [7:0]  DQ_out,
    output logic        DQ_oe,
    output logic        busy,
    output logic        timeout_err,
    input  logic        err_clr
);

    logic rd_s, rd_fall;
    logic cs_s, cs_fall_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (RD),
        .sync (rd_s),
        .fall (rd_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (CS_n),
        .sync (cs_s),
        .fall (cs_fall_unused)
    );

    rd_state_e  state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] sub_addr_q, sub_addr_d;
    logic [7:0] dq_q, dq_d;
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d, err_set;
    logic       oe_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            sub_addr_q <= '0;
            dq_q       <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sub_addr_q <= sub_addr_d;
            dq_q       <= dq_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            // Pad drive follows the strobes directly, independent of the FSM
            oe_q       <= ~rd_s & ~cs_s;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sub_addr_d = sub_addr_q;
        dq_d       = dq_q;
        cnt_d      = cnt_q;
        err_set    = 1'b0;
        rd_req     = '0;

        unique case (state_q)
            IDLE: begin
                // Falls seen outside IDLE are simply never looked at
                if (rd_fall && !cs_s) begin
                    sub_addr_d = Addr[3:0];
                    if (Addr[7:4] == ADDR_XIN) begin
                        dq_d    = Xin;
                        state_d = HOLD;
                    end else if (is_axis(Addr[7:4])) begin
                        idx_d   = axis_index(Addr[7:4]);
                        state_d = REQ;
                    end else begin
                        dq_d    = 8'h00;
                        state_d = HOLD;
                    end
                end
            end
            REQ: begin
                cnt_d = '0;
                if (rd_s) begin
                    state_d = IDLE;
                end else begin
                    rd_req  = 8'(1) << idx_q;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Abort beats ack; ack beats timeout
                if (rd_s) begin
                    state_d = IDLE;
                end else if (axis_ack[idx_q]) begin
                    dq_d    = axis_data[{idx_q, 3'b000} +: 8];
                    state_d = HOLD;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    dq_d    = ERR_BYTE;
                    err_set = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (rd_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (err_clr) begin
            err_d = 1'b0;
        end else if (err_set) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    assign sub_addr    = sub_addr_q;
    assign DQ_out      = dq_q;
    assign DQ_oe       = oe_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = err_q;

endmodule
